// File: rtl/wb_checker.sv
`default_nettype none
// ============================================================================
// Module   : wb_checker
// Purpose  : Compares a core's register-file writeback stream against a
//            preloaded expected trace and reports pass/fail with diagnostics.
// Revision : 1.0
// ============================================================================
module wb_checker #(
   parameter  int WORD       = 64,
   parameter  int RADDR_W    = 5,
   parameter  int DEPTH      = 16,
   parameter  int TIMEOUT    = 1024,
   parameter  int IGNORE_XZR = 1,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               exp_we,
   input  logic [IDX_W-1:0]   exp_idx,
   input  logic [RADDR_W-1:0] exp_addr,
   input  logic [WORD-1:0]    exp_data,
   input  logic [IDX_W:0]     exp_num,
   input  logic               start,
   input  logic               wb_valid,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [WORD-1:0]    wb_data,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic               fail,
   output logic [IDX_W:0]     mismatch_cnt,
   output logic [IDX_W:0]     checked_cnt,
   output logic [IDX_W-1:0]   first_fail_idx,
   output logic [WORD-1:0]    first_fail_data,
   output logic               timed_out
);

   localparam int             TMR_W       = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W:0] DEPTH_CNT   = (IDX_W + 1)'(DEPTH);
   localparam logic [TMR_W-1:0] TIMEOUT_CNT = TMR_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W:0]     num_q, num_d;
   logic [IDX_W:0]     chk_q, chk_d;
   logic [IDX_W:0]     mis_q, mis_d;
   logic [IDX_W-1:0]   ffi_q, ffi_d;
   logic [WORD-1:0]    ffd_q, ffd_d;
   logic               to_q, to_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               busy_q, done_q, pass_q, fail_q;
   logic               busy_d, done_d, pass_d, fail_d;

   logic [RADDR_W-1:0] mem_addr_q [DEPTH];
   logic [WORD-1:0]    mem_data_q [DEPTH];

   logic               accept_w;
   logic               miss_w;
   logic               num_ok_w;
   logic               num_ok_d;

   assign accept_w = wb_valid && !((IGNORE_XZR != 0) && (&wb_addr));
   assign miss_w   = (mem_addr_q[chk_q[IDX_W-1:0]] != wb_addr) ||
                     (mem_data_q[chk_q[IDX_W-1:0]] != wb_data);
   assign num_ok_w = (exp_num != '0) && (exp_num <= DEPTH_CNT);
   assign num_ok_d = (num_d != '0) && (num_d <= DEPTH_CNT);

   // Trace memory is deliberately not reset so a rerun after rst reuses it.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && exp_we && !rst) begin
         mem_addr_q[exp_idx] <= exp_addr;
         mem_data_q[exp_idx] <= exp_data;
      end
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      chk_d   = chk_q;
      mis_d   = mis_q;
      ffi_d   = ffi_q;
      ffd_d   = ffd_q;
      to_d    = to_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               num_d   = exp_num;
               chk_d   = '0;
               mis_d   = '0;
               ffi_d   = '0;
               ffd_d   = '0;
               to_d    = 1'b0;
               tmr_d   = '0;
               state_d = num_ok_w ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (accept_w) begin
               chk_d = chk_q + (IDX_W + 1)'(1);
               if (miss_w) begin
                  if (mis_q == '0) begin
                     ffi_d = chk_q[IDX_W-1:0];
                     ffd_d = wb_data;
                  end
                  if (mis_q != DEPTH_CNT) mis_d = mis_q + (IDX_W + 1)'(1);
               end
            end
            // Completion takes priority over a coincident timeout.
            if (accept_w && chk_d == num_q) begin
               state_d = S_DONE;
            end else if (tmr_d == TIMEOUT_CNT) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
      pass_d = done_d && num_ok_d && (mis_d == '0) && !to_d;
      fail_d = done_d && !pass_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         chk_q   <= '0;
         mis_q   <= '0;
         ffi_q   <= '0;
         ffd_q   <= '0;
         to_q    <= 1'b0;
         tmr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         chk_q   <= chk_d;
         mis_q   <= mis_d;
         ffi_q   <= ffi_d;
         ffd_q   <= ffd_d;
         to_q    <= to_d;
         tmr_q   <= tmr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign fail            = fail_q;
   assign mismatch_cnt    = mis_q;
   assign checked_cnt     = chk_q;
   assign first_fail_idx  = ffi_q;
   assign first_fail_data = ffd_q;
   assign timed_out       = to_q;

endmodule
`default_nettype wire
